// File: rtl/ram_wbuf.sv
// rtl/ram_wbuf.sv - posted-write buffer between CPU load/store port and RAM bridge.
// Optional store-to-load forwarding is enabled by defining WBUF_FWD_EN.
module ram_wbuf #(
   parameter int BUS_WIDTH  = 32,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    cpu_ren,
   input  logic [BUS_WIDTH-1:0]    cpu_raddr,
   output logic                    cpu_rstall,
   output logic                    cpu_rvalid,
   output logic [DATA_WIDTH-1:0]   cpu_rdata,
   input  logic [DATA_WIDTH/8-1:0] cpu_wen,
   input  logic [BUS_WIDTH-1:0]    cpu_waddr,
   input  logic [DATA_WIDTH-1:0]   cpu_wdata,
   output logic                    cpu_wready,
   output logic                    wbuf_empty,
   output logic                    m_ren,
   output logic [BUS_WIDTH-1:0]    m_raddr,
   input  logic [DATA_WIDTH-1:0]   m_rdata,
   output logic [DATA_WIDTH/8-1:0] m_wen,
   output logic [BUS_WIDTH-1:0]    m_waddr,
   output logic [DATA_WIDTH-1:0]   m_wdata,
   input  logic                    m_wready
);
   localparam int BE_W  = DATA_WIDTH / 8;
   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);
   localparam logic [0:0] R_IDLE = 1'b0;
   localparam logic [0:0] R_DATA = 1'b1;

   logic [BUS_WIDTH-1:0]  addr_q [DEPTH];
   logic [DATA_WIDTH-1:0] data_q [DEPTH];
   logic [BE_W-1:0]       wen_q  [DEPTH];
   logic [PTR_W-1:0]      head, tail;
   logic [PTR_W:0]        count;
   logic [0:0]            r_state;
   logic                  push, pop, hit, accept;

   assign cpu_wready = (count != FULL_CNT);
   assign wbuf_empty = (count == '0);
   assign push       = (|cpu_wen) & cpu_wready;
   assign pop        = (|m_wen) & m_wready;
   assign m_wen      = wbuf_empty ? '0 : wen_q[head];
   assign m_waddr    = addr_q[head];
   assign m_wdata    = data_q[head];
   assign m_raddr    = cpu_raddr;
   assign accept     = cpu_ren & ~cpu_rstall;
   assign cpu_rvalid = (r_state == R_DATA);

`ifdef WBUF_FWD_EN
   logic [PTR_W-1:0]      young;
   logic                  fwd_hit, fwd_sel_q;
   logic [DATA_WIDTH-1:0] fwd_data_q;
`endif

   // Walk entries oldest to youngest so the last match found is the youngest.
   always_comb begin
      hit = 1'b0;
`ifdef WBUF_FWD_EN
      young = head;
`endif
      for (int k = 0; k < DEPTH; k++) begin
         if (((PTR_W + 1)'(k) < count) &&
             (addr_q[head + PTR_W'(k)][BUS_WIDTH-1:2] == cpu_raddr[BUS_WIDTH-1:2])) begin
            hit = cpu_ren;
`ifdef WBUF_FWD_EN
            young = head + PTR_W'(k);
`endif
         end
      end
   end

`ifdef WBUF_FWD_EN
   assign fwd_hit    = hit & (&wen_q[young]);
   assign cpu_rstall = hit & ~fwd_hit;
   assign m_ren      = accept & ~fwd_hit;
   assign cpu_rdata  = cpu_rvalid ? (fwd_sel_q ? fwd_data_q : m_rdata) : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fwd_sel_q  <= 1'b0;
         fwd_data_q <= '0;
      end else begin
         fwd_sel_q  <= fwd_hit;
         fwd_data_q <= data_q[young];
      end
   end
`else
   assign cpu_rstall = hit;
   assign m_ren      = accept;
   assign cpu_rdata  = cpu_rvalid ? m_rdata : '0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head    <= '0;
         tail    <= '0;
         count   <= '0;
         r_state <= R_IDLE;
      end else begin
         if (push) tail <= tail + 1'b1;
         if (pop)  head <= head + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (!push && pop) count <= count - 1'b1;
         r_state <= accept ? R_DATA : R_IDLE;
      end
   end

   // Storage needs no reset: entries are only meaningful while counted.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[tail] <= cpu_waddr;
         data_q[tail] <= cpu_wdata;
         wen_q[tail]  <= cpu_wen;
      end
   end
endmodule

// File: tb/tb_ram_wbuf.sv
// tb/tb_ram_wbuf.sv - scoreboard bench for ram_wbuf against a queue-based reference model.
module tb_ram_wbuf;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_ren;
   logic [31:0] cpu_raddr;
   logic        cpu_rstall, cpu_rvalid;
   logic [31:0] cpu_rdata;
   logic [3:0]  cpu_wen;
   logic [31:0] cpu_waddr, cpu_wdata;
   logic        cpu_wready, wbuf_empty;
   logic        m_ren;
   logic [31:0] m_raddr, m_rdata;
   logic [3:0]  m_wen;
   logic [31:0] m_waddr, m_wdata;
   logic        m_wready;

   ram_wbuf #(.BUS_WIDTH(32), .DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .cpu_ren(cpu_ren), .cpu_raddr(cpu_raddr), .cpu_rstall(cpu_rstall),
      .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .cpu_wen(cpu_wen), .cpu_waddr(cpu_waddr), .cpu_wdata(cpu_wdata),
      .cpu_wready(cpu_wready), .wbuf_empty(wbuf_empty),
      .m_ren(m_ren), .m_raddr(m_raddr), .m_rdata(m_rdata),
      .m_wen(m_wen), .m_waddr(m_waddr), .m_wdata(m_wdata), .m_wready(m_wready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  w;
   } st_t;

   st_t         wq[$];
   logic [31:0] rexp[$];
   int          n_checks = 0;
   int          n_fail = 0;
   logic        prev_ren = 1'b0;
   logic [31:0] prev_addr = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] bridge_data(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
   endfunction

   // One CPU cycle: drive, compare combinational outputs with the model, advance the model.
   task automatic cycle(input logic ren, input logic [31:0] raddr, input logic [3:0] wen,
                        input logic [31:0] waddr, input logic [31:0] wdata, input logic mwr,
                        output logic stalled, output logic wacc);
      logic hit, fwd, can_push;
      int   yi;
      @(negedge clk);
      m_rdata   = prev_ren ? bridge_data(prev_addr) : $urandom;
      cpu_ren   = ren;
      cpu_raddr = raddr;
      cpu_wen   = wen;
      cpu_waddr = waddr;
      cpu_wdata = wdata;
      m_wready  = mwr;
      #2;
      hit = 1'b0;
      fwd = 1'b0;
      yi  = 0;
      foreach (wq[i]) if (wq[i].a[31:2] == raddr[31:2]) begin hit = 1'b1; yi = i; end
      hit = hit & ren;
`ifdef WBUF_FWD_EN
      fwd = hit && (wq[yi].w == 4'hF);
`endif
      stalled  = hit & ~fwd;
      can_push = (wq.size() != DEPTH);
      chk("cpu_rstall", cpu_rstall, stalled);
      chk("m_ren", m_ren, ren & ~hit);
      chk("cpu_wready", cpu_wready, can_push);
      chk("wbuf_empty", wbuf_empty, wq.size() == 0);
      if (ren) chk("m_raddr", m_raddr, raddr);
      if (wq.size() != 0) begin
         chk("m_wen", m_wen, wq[0].w);
         chk("m_waddr", m_waddr, wq[0].a);
         chk("m_wdata", m_wdata, wq[0].d);
      end else begin
         chk("m_wen_empty", m_wen, 4'h0);
      end
      if (ren && !stalled) rexp.push_back(fwd ? wq[yi].d : bridge_data(raddr));
      prev_ren  = ren & ~hit;
      prev_addr = raddr;
      if (mwr && wq.size() != 0) void'(wq.pop_front());
      wacc = (wen != 0) && can_push;
      if (wacc) wq.push_back('{a: waddr, d: wdata, w: wen});
   endtask

   task automatic idle(input logic mwr);
      logic s, w;
      cycle(1'b0, 32'h0, 4'h0, 32'h0, 32'h0, mwr, s, w);
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w,
                        input logic mwr);
      logic s, acc;
      cycle(1'b0, 32'h0, w, a, d, mwr, s, acc);
   endtask

   task automatic drain();
      int n = 0;
      while (wq.size() != 0 && n < 20) begin idle(1'b1); n++; end
      chk("drain_bound", wq.size(), 0);
      idle(1'b1);
   endtask

   // Read-response monitor: pops expected data whenever the DUT presents cpu_rvalid.
   always @(negedge clk) begin
      #1;
      if (!reset) begin
         if (cpu_rvalid) begin
            if (rexp.size() == 0) chk("spurious_rvalid", 1'b1, 1'b0);
            else chk("cpu_rdata", cpu_rdata, rexp.pop_front());
         end else if (rexp.size() != 0) begin
            chk("rvalid_missing", 1'b0, 1'b1);
            rexp.delete();
         end
      end
   end

   initial begin
      logic s, acc;
      int   n;
      logic        hold_ren;
      logic [31:0] hold_addr;
      reset = 1'b1; cpu_ren = 1'b0; cpu_raddr = '0; cpu_wen = 4'hF;
      cpu_waddr = 32'h40; cpu_wdata = 32'h1234; m_wready = 1'b0; m_rdata = '0;
      // Reset with a store request asserted
      #1;
      chk("rst_empty", wbuf_empty, 1'b1);
      chk("rst_m_wen", m_wen, 4'h0);
      chk("rst_wready", cpu_wready, 1'b1);
      chk("rst_rvalid", cpu_rvalid, 1'b0);
      chk("rst_rdata", cpu_rdata, 32'h0);
      @(posedge clk); #1;
      chk("rst_no_push", wbuf_empty, 1'b1);
      @(negedge clk);
      cpu_wen = 4'h0;
      reset = 1'b0;

      // Fill with drain blocked; fifth store refused
      for (int i = 0; i < 5; i++) store(32'h100 + 32'(i) * 4, 32'hA000 + 32'(i), 4'hF, 1'b0);
      chk("fill_count", wq.size(), 4);
      for (int i = 0; i < 4; i++) idle(1'b1);
      idle(1'b0);

      // Full FIFO while draining: held store refused then accepted
      for (int i = 0; i < 4; i++) store(32'h180 + 32'(i) * 4, 32'hB000 + 32'(i), 4'hF, 1'b0);
      n = 0;
      acc = 1'b0;
      while (!acc && n < 4) begin cycle(1'b0, 0, 4'h5, 32'h1C0, 32'hC0FFEE, 1'b1, s, acc); n++; end
      chk("held_store_tries", n, 2);
      drain();

      // Load hitting a queued store
      store(32'h200, 32'hDEADBEEF, 4'hF, 1'b0);
      for (int i = 0; i < 3; i++) cycle(1'b1, 32'h202, 0, 0, 0, 1'b0, s, acc);
      n = 0;
      s = 1'b1;
      while (s && n < 4) begin cycle(1'b1, 32'h202, 0, 0, 0, 1'b1, s, acc); n++; end
      idle(1'b1);

      // Youngest match partial: stall even with forwarding
      store(32'h300, 32'h11111111, 4'hF, 1'b0);
      store(32'h300, 32'h22222222, 4'h3, 1'b0);
      for (int i = 0; i < 2; i++) cycle(1'b1, 32'h300, 0, 0, 0, 1'b0, s, acc);
      chk("partial_stall", s, 1'b1);
      drain();

      // Back-to-back loads, empty FIFO
      for (int i = 0; i < 3; i++) cycle(1'b1, 32'h400 + 32'(i) * 4, 0, 0, 0, 1'b1, s, acc);
      idle(1'b1);
      idle(1'b1);

      // Randomized traffic; stalled loads are held by the CPU
      hold_ren = 1'b0;
      hold_addr = '0;
      for (int i = 0; i < 600; i++) begin
         logic        r;
         logic [31:0] ra;
         logic [3:0]  w;
         if (hold_ren) begin r = 1'b1; ra = hold_addr; end
         else begin
            r  = $urandom_range(0, 1) == 1;
            ra = 32'h500 + 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(0, 3));
         end
         w = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
         if ($urandom_range(0, 3) == 0) w = 4'hF;
         cycle(r, ra, w, 32'h500 + 32'($urandom_range(0, 7)) * 4, $urandom,
               $urandom_range(0, 2) != 0, s, acc);
         hold_ren  = s;
         hold_addr = ra;
      end
      drain();

      // Asynchronous reset while draining three entries
      for (int i = 0; i < 3; i++) store(32'h600 + 32'(i) * 4, 32'hE000 + 32'(i), 4'hF, 1'b0);
      idle(1'b1);
      @(posedge clk);
      #3 reset = 1'b1;
      #1;
      chk("arst_m_wen", m_wen, 4'h0);
      chk("arst_empty", wbuf_empty, 1'b1);
      chk("arst_wready", cpu_wready, 1'b1);
      wq.delete();
      rexp.delete();
      prev_ren = 1'b0;
      @(negedge clk);
      #3 reset = 1'b0;
      idle(1'b1);
      idle(1'b1);
      cycle(1'b1, 32'h604, 0, 0, 0, 1'b0, s, acc);
      chk("arst_no_hit", s, 1'b0);
      idle(1'b0);
      idle(1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
